fft16_serializer: RTL and testbench

FFT16_SERIALIZER -- requirements
Module: fft16_serializer

---
 rtl/fft16_pkg.sv | 11 +
 rtl/fft16_bank.sv | 38 +++
 rtl/fft16_serializer.sv | 98 +++++++++
 tb/tb_fft16_serializer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared constants and index helpers for the 16-point frame serializer.
package fft16_pkg;
  localparam int NPOINT = 16;
  localparam int IDX_W  = 4;
  localparam int N_DEF  = 16;
  localparam logic [IDX_W-1:0] LAST_CNT = 4'(NPOINT - 1);

  function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction
endpackage

// File: rtl/fft16_bank.sv
// 16-entry complex register bank: whole-frame parallel load, async clear,
// one combinational read port selected by a 4-bit index.
module fft16_bank
  import fft16_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [NPOINT*N-1:0] i_re,
  input  logic [NPOINT*N-1:0] i_im,
  input  logic [IDX_W-1:0]    i_idx,
  output logic [N-1:0]        o_re,
  output logic [N-1:0]        o_im
);

  logic [N-1:0] re_q [NPOINT];
  logic [N-1:0] im_q [NPOINT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NPOINT; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else if (i_load) begin
      for (int k = 0; k < NPOINT; k++) begin
        re_q[k] <= i_re[k*N +: N];
        im_q[k] <= i_im[k*N +: N];
      end
    end
  end

  assign o_re = re_q[i_idx];
  assign o_im = im_q[i_idx];

endmodule

// File: rtl/fft16_serializer.sv
// Serializes a parallel-loaded 16-point complex frame into 16 valid/ready beats,
// optionally in bit-reversed order; a load during the last transfer chains frames.
module fft16_serializer
  import fft16_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int BITREV = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [NPOINT*N-1:0] i_re,
  input  logic [NPOINT*N-1:0] i_im,
  output logic                o_load_ready,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [N-1:0]        o_re,
  output logic [N-1:0]        o_im,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_last,
  output logic                o_ovr
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             bank_load;
  logic             load_rdy;
  logic [IDX_W-1:0] rd_idx;
  logic [N-1:0]     bank_re, bank_im;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bank_load = 1'b0;
    load_rdy  = (state_q == IDLE) ||
                ((state_q == STREAM) && (cnt_q == LAST_CNT) && i_ready);
    ovr_d     = i_load && !load_rdy;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          bank_load = 1'b1;
          state_d   = STREAM;
          cnt_d     = '0;
        end
      end
      STREAM: begin
        if (i_ready) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            // A load on the final transfer keeps streaming with no bubble.
            if (i_load) bank_load = 1'b1;
            else        state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_idx = (BITREV != 0) ? bitrev4(cnt_q) : cnt_q;

  fft16_bank #(.N(N)) u_bank (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (bank_load),
    .i_re   (i_re),
    .i_im   (i_im),
    .i_idx  (rd_idx),
    .o_re   (bank_re),
    .o_im   (bank_im)
  );

  assign o_load_ready = load_rdy;
  assign o_valid      = (state_q == STREAM);
  assign o_re         = o_valid ? bank_re : '0;
  assign o_im         = o_valid ? bank_im : '0;
  assign o_idx        = o_valid ? rd_idx : '0;
  assign o_last       = o_valid && (cnt_q == LAST_CNT);
  assign o_ovr        = ovr_q;

endmodule

// File: tb/tb_fft16_serializer.sv
// Directed, table-driven bench for fft16_serializer (bit-reversed and natural order).
module tb_fft16_serializer;
  localparam int N = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_load;
  logic          i_ready;
  logic [16*N-1:0] i_re, i_im;

  logic          lrdy, vld, last, ovr;
  logic [N-1:0]  ore, oim;
  logic [3:0]    oidx;
  logic          n_lrdy, n_vld, n_last, n_ovr;
  logic [N-1:0]  n_re, n_im;
  logic [3:0]    n_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  fft16_serializer #(.N(N), .BITREV(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_re(i_re), .i_im(i_im),
    .o_load_ready(lrdy), .o_valid(vld), .i_ready(i_ready), .o_re(ore), .o_im(oim),
    .o_idx(oidx), .o_last(last), .o_ovr(ovr)
  );

  fft16_serializer #(.N(N), .BITREV(0)) dut_nat (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_re(i_re), .i_im(i_im),
    .o_load_ready(n_lrdy), .o_valid(n_vld), .i_ready(i_ready), .o_re(n_re), .o_im(n_im),
    .o_idx(n_idx), .o_last(n_last), .o_ovr(n_ovr)
  );

  typedef struct {
    logic        ready;
    logic        load;
    logic        sel_b;
    logic        exp_vld;
    logic [15:0] exp_re;
    logic        exp_last;
    logic        exp_ovr;
    logic        exp_lrdy;
  } vec_t;

  vec_t tbl [23];
  logic [3:0] br_seq [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame A: re=k, im=0x0100+k. Frame B: re=0x1000+k, im=0x1100+k.
  task automatic set_frame(input logic sel_b);
    for (int k = 0; k < 16; k++) begin
      i_re[k*N +: N] = (sel_b ? 16'h1000 : 16'h0000) + 16'(k);
      i_im[k*N +: N] = (sel_b ? 16'h1100 : 16'h0100) + 16'(k);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic ld, input logic sb, input logic ev,
                              input logic [15:0] er, input logic el, input logic eo,
                              input logic elr);
    vec_t v;
    v.ready = r; v.load = ld; v.sel_b = sb; v.exp_vld = ev; v.exp_re = er;
    v.exp_last = el; v.exp_ovr = eo; v.exp_lrdy = elr;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    br_seq = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
               4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    // Backpressure / overrun / back-to-back vectors, one row per cycle.
    tbl[0]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 1);
    tbl[1]  = mk(1, 0, 0, 1, 16'd0,  0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 1, 16'd8,  0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 16'd4,  0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 16'd12, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 16'd12, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 16'd12, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 1, 16'd12, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 16'd2,  0, 0, 0);
    tbl[9]  = mk(1, 1, 1, 1, 16'd10, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 1, 16'd6,  0, 1, 0);
    tbl[11] = mk(1, 0, 0, 1, 16'd14, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 1, 16'd1,  0, 0, 0);
    tbl[13] = mk(1, 0, 0, 1, 16'd9,  0, 0, 0);
    tbl[14] = mk(1, 0, 0, 1, 16'd5,  0, 0, 0);
    tbl[15] = mk(1, 0, 0, 1, 16'd13, 0, 0, 0);
    tbl[16] = mk(1, 0, 0, 1, 16'd3,  0, 0, 0);
    tbl[17] = mk(1, 0, 0, 1, 16'd11, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 1, 16'd7,  0, 0, 0);
    tbl[19] = mk(1, 1, 1, 1, 16'd15, 1, 0, 1);
    tbl[20] = mk(1, 0, 1, 1, 16'h1000, 0, 0, 0);
    tbl[21] = mk(0, 0, 1, 1, 16'h1008, 0, 0, 0);
    tbl[22] = mk(0, 0, 1, 1, 16'h1008, 0, 0, 0);

    i_rst = 1'b1; i_load = 1'b0; i_ready = 1'b0;
    set_frame(1'b0);

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_re", 32'(ore), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("rst_lrdy", 32'(lrdy), 32'd1);

    // Ordering: bit-reversed on dut, natural on dut_nat
    @(negedge i_clk);
    i_load = 1'b1; i_ready = 1'b1; set_frame(1'b0);
    #1;
    chk("ord_lrdy_idle", 32'(lrdy), 32'd1);
    chk("ord_valid_pre", 32'(vld), 32'd0);
    for (int b = 0; b < 16; b++) begin
      @(negedge i_clk);
      i_load = 1'b0;
      #1;
      chk("ord_valid", 32'(vld), 32'd1);
      chk("ord_re", 32'(ore), 32'(br_seq[b]));
      chk("ord_im", 32'(oim), 32'h0100 + 32'(br_seq[b]));
      chk("ord_idx", 32'(oidx), 32'(br_seq[b]));
      chk("ord_last", 32'(last), (b == 15) ? 32'd1 : 32'd0);
      chk("nat_re", 32'(n_re), 32'(b));
      chk("nat_idx", 32'(n_idx), 32'(b));
      chk("nat_last", 32'(n_last), (b == 15) ? 32'd1 : 32'd0);
    end
    @(negedge i_clk);
    #1;
    chk("ord_valid_post", 32'(vld), 32'd0);
    chk("ord_re_post", 32'(ore), 32'd0);
    chk("nat_valid_post", 32'(n_vld), 32'd0);

    // Table: backpressure, overrun, back-to-back
    for (int r = 0; r < 23; r++) begin
      @(negedge i_clk);
      i_ready = tbl[r].ready;
      i_load  = tbl[r].load;
      set_frame(tbl[r].sel_b);
      #1;
      chk($sformatf("tbl%0d_valid", r), 32'(vld), 32'(tbl[r].exp_vld));
      chk($sformatf("tbl%0d_re", r), 32'(ore), 32'(tbl[r].exp_re));
      chk($sformatf("tbl%0d_im", r), 32'(oim),
          tbl[r].exp_vld ? 32'(tbl[r].exp_re) + 32'h0100 : 32'd0);
      chk($sformatf("tbl%0d_last", r), 32'(last), 32'(tbl[r].exp_last));
      chk($sformatf("tbl%0d_ovr", r), 32'(ovr), 32'(tbl[r].exp_ovr));
      chk($sformatf("tbl%0d_lrdy", r), 32'(lrdy), 32'(tbl[r].exp_lrdy));
    end

    // Mid-stream reset: advance frame B to beat 7, then reset
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      i_ready = 1'b1; i_load = 1'b0;
    end
    @(negedge i_clk);
    i_ready = 1'b0;
    #1;
    chk("mid_beat7_re", 32'(ore), 32'h1000 + 32'(br_seq[7]));
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(vld), 32'd0);
    chk("mid_rst_re", 32'(ore), 32'd0);
    chk("mid_rst_idx", 32'(oidx), 32'd0);
    chk("mid_rst_last", 32'(last), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0; i_ready = 1'b1;
    #1;
    chk("mid_rel_lrdy", 32'(lrdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      #1;
      chk("mid_no_beats", 32'(vld), 32'd0);
    end
    @(negedge i_clk);
    i_load = 1'b1; set_frame(1'b0);
    @(negedge i_clk);
    i_load = 1'b0;
    #1;
    chk("restart_b0_re", 32'(ore), 32'd0);
    chk("restart_b0_vld", 32'(vld), 32'd1);
    @(negedge i_clk);
    #1;
    chk("restart_b1_re", 32'(ore), 32'd8);
    chk("restart_b1_idx", 32'(oidx), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
